// File: rtl/fetch_align_pkg.sv
// Shared definitions for the fetch/realign stage: FSM encoding, queue sizing, RVC length decode.
// Used by fetch_align (RVC support selected by the FETCH_RVC_EN macro) and fetch_hw_queue.
package fetch_align_pkg;

  localparam int         QUEUE_DEPTH = 4;
  localparam int         CNT_W       = 3;
  localparam logic [1:0] RVC_MASK    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_t;

  // A halfword starts a compressed instruction unless its two low bits are both set.
  function automatic logic hw_is_rvc(input logic [15:0] hw);
    return (hw[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

  // Byte at PC lands in [31:24]; the second halfword is zeroed for RVC.
  function automatic logic [31:0] fmt_instr(input logic [15:0] lo, input logic [15:0] hi,
                                            input logic rvc);
    return {lo[7:0], lo[15:8], (rvc ? 16'h0000 : {hi[7:0], hi[15:8]})};
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Four-entry halfword FIFO feeding the realigner: push 0/1/2 and pop 0/1/2 per cycle, flush.
// Callers guarantee no overflow/underflow; the count output is the only occupancy indication.
module fetch_hw_queue
  import fetch_align_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       push_num,
  input  logic [15:0]      push_hw0,
  input  logic [15:0]      push_hw1,
  input  logic [1:0]       pop_num,
  output logic [15:0]      head0,
  output logic [15:0]      head1,
  output logic [CNT_W-1:0] count
);

  logic [15:0] mem [QUEUE_DEPTH];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;

  // NOTE: storage has no reset; count qualifies every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (!flush && push_num != 2'd0) mem[wr_ptr] <= push_hw0;
    if (!flush && push_num == 2'd2) mem[wr_ptr + 2'd1] <= push_hw1;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_num;
      rd_ptr <= rd_ptr + pop_num;
      count  <= count + {1'b0, push_num} - {1'b0, pop_num};
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + 2'd1];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch and realign stage: word fetch FSM, halfword queue, whole-instruction output.
// Define FETCH_RVC_EN for 16-bit compressed instruction support; otherwise all instructions are 32-bit.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_rvc
);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [CNT_W-1:0] count;
  logic [15:0]      head0;
  logic [15:0]      head1;
  logic             head_rvc;
  logic             skip_lo;
  logic             xfer;
  logic             push_ok;
  logic [1:0]       push_num;
  logic [1:0]       pop_num;
  logic [15:0]      push_hw0;
  logic [31:0]      redir_pc;

`ifdef FETCH_RVC_EN
  localparam logic RESET_SKIP = RESET_PC[1];
  assign head_rvc = hw_is_rvc(head0);
  assign redir_pc = {redirect_pc[31:1], 1'b0};
`else
  localparam logic RESET_SKIP = 1'b0;
  assign head_rvc = 1'b0;
  assign redir_pc = {redirect_pc[31:2], 2'b00};
`endif

  // A redirect hides whatever is queued in the same cycle it flushes it.
  assign instr_valid  = !redirect_valid &&
                        ((count >= 3'd1 && head_rvc) || count >= 3'd2);
  assign instr_is_rvc = instr_valid && head_rvc;
  assign instr_data   = instr_valid ? fmt_instr(head0, head1, head_rvc) : 32'h0;
  assign xfer         = instr_valid && instr_ready;
  assign pop_num      = !xfer ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);

  // count<=2 leaves room for a full word, so an issued request can never overflow the queue.
  assign imem_req = reset && (state == ST_IDLE) && (count <= 3'd2) && !redirect_valid;
  assign push_ok  = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign push_num = !push_ok ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
  assign push_hw0 = skip_lo ? imem_rdata[31:16] : imem_rdata[15:0];

  fetch_hw_queue u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_num (push_num),
    .push_hw0 (push_hw0),
    .push_hw1 (imem_rdata[31:16]),
    .pop_num  (pop_num),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  // NOTE: next state is defaulted first so no path through the block leaves it unassigned.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (imem_req)    state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_nxt = ST_IDLE;
      ST_KILL: if (imem_rvalid) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
    // An outstanding response must be drained before the redirected fetch can issue.
    if (redirect_valid) begin
      if (imem_rvalid)            state_nxt = ST_IDLE;
      else if (state != ST_IDLE)  state_nxt = ST_KILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      instr_pc  <= RESET_PC;
      imem_addr <= {RESET_PC[31:2], 2'b00};
      skip_lo   <= RESET_SKIP;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        instr_pc  <= redir_pc;
        imem_addr <= {redir_pc[31:2], 2'b00};
        skip_lo   <= redir_pc[1];
      end else begin
        if (xfer)    instr_pc <= instr_pc + (head_rvc ? 32'd2 : 32'd4);
        if (push_ok) begin
          imem_addr <= imem_addr + 32'd4;
          skip_lo   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: directed programs, a latency-configurable memory model,
// and a monitor that checks every decode-side transfer. Expectations follow FETCH_RVC_EN.
module tb_fetch_align;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_rvc;

  fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_is_rvc   (instr_is_rvc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        rvc;
    int          cyc;   // -1 = cycle not checked
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          mem_lat = 1;
  int          lat_cnt;
  logic [31:0] raddr;
  logic [31:0] mem [256];
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: one request at a time, response mem_lat cycles after the request cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc         <= 0;
      lat_cnt     <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      cyc         <= cyc + 1;
      imem_rvalid <= 1'b0;
      if (lat_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem[raddr[9:2]];
      end
      if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
      if (imem_req) begin
        req_addr_log.push_back(imem_addr);
        req_cyc_log.push_back(cyc);
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem[imem_addr[9:2]];
        end else begin
          lat_cnt <= mem_lat - 1;
          raddr   <= imem_addr;
        end
      end
    end
  end

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_xfer: got pc %h data %h expected no transfer", instr_pc, instr_data);
      end else begin
        mon_e = sb.pop_front();
        check("xfer_data", instr_data, mon_e.data);
        check("xfer_pc", instr_pc, mon_e.pc);
        check("xfer_rvc", {31'b0, instr_is_rvc}, {31'b0, mon_e.rvc});
        if (mon_e.cyc >= 0) check("xfer_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic push_exp(input logic [31:0] data, input logic [31:0] pc, input logic rvc,
                          input int c);
    exp_t e;
    e.data = data;
    e.pc   = pc;
    e.rvc  = rvc;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic load(input int idx, input logic [31:0] w);
    mem[idx] = w;
  endtask

  // Asserts reset (possibly mid-operation), checks reset values, releases on a falling edge.
  task automatic do_reset(input int lat);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    mem_lat        = lat;
    #3;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr_pc", instr_pc, RESET_PC);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_is_rvc", {31'b0, instr_is_rvc}, 32'h0);
    repeat (2) @(posedge clk);
    req_addr_log.delete();
    req_cyc_log.delete();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d transfers still pending expected 0", name, sb.size());
      sb.delete();
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Single 32-bit addi followed by a nop: request at cycle 0, first transfer at cycle 2.
    load(0, 32'h0051_0093);
    load(1, 32'h0000_0013);
    do_reset(1);
    push_exp(32'h9300_5100, 32'h0, 1'b0, 2);
    push_exp(32'h1300_0000, 32'h4, 1'b0, 4);
    instr_ready = 1'b1;
    wait_drain("t1_drain");
    check("t1_req_count_min", {31'b0, req_addr_log.size() >= 2}, 32'h1);
    check("t1_req0_addr", req_addr_log[0], 32'h0);
    check("t1_req0_cycle", req_cyc_log[0], 32'd0);
    check("t1_req1_addr", req_addr_log[1], 32'h4);

    // Two c.li in one word, then a 32-bit addi.
    load(0, 32'h4505_4501);
    load(1, 32'h0051_0093);
    do_reset(1);
`ifdef FETCH_RVC_EN
    push_exp(32'h0145_0000, 32'h0, 1'b1, 2);
    push_exp(32'h0545_0000, 32'h2, 1'b1, 3);
`else
    push_exp(32'h0145_0545, 32'h0, 1'b0, 2);
`endif
    push_exp(32'h9300_5100, 32'h4, 1'b0, 4);
    instr_ready = 1'b1;
    wait_drain("t2_drain");

    // 32-bit instruction straddling the word boundary in RVC builds.
    load(0, 32'h0093_4501);
    load(1, 32'hABCD_0051);
    do_reset(1);
`ifdef FETCH_RVC_EN
    push_exp(32'h0145_0000, 32'h0, 1'b1, 2);
    push_exp(32'h9300_5100, 32'h2, 1'b0, 4);
`else
    push_exp(32'h0145_9300, 32'h0, 1'b0, 2);
    push_exp(32'h5100_CDAB, 32'h4, 1'b0, 4);
`endif
    instr_ready = 1'b1;
    wait_drain("t3_drain");

    // Redirect to 0x102 while the first request waits on 3-cycle memory.
    load(0, 32'h4501_4501);
    load(8'h40, 32'h4585_0013);
    load(8'h41, 32'h0051_0093);
    do_reset(3);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
`ifdef FETCH_RVC_EN
    push_exp(32'h8545_0000, 32'h102, 1'b1, 8);
`else
    push_exp(32'h1300_8545, 32'h100, 1'b0, 8);
`endif
    push_exp(32'h9300_5100, 32'h104, 1'b0, -1);
    wait_drain("t4_drain");
    check("t4_req_count_min", {31'b0, req_addr_log.size() >= 2}, 32'h1);
    check("t4_req1_addr", req_addr_log[1], 32'h100);
    check("t4_req1_cycle", req_cyc_log[1], 32'd4);

    // Decode stalled: the queue fills to four halfwords and fetching stops.
    load(0, 32'h0051_0093);
    load(1, 32'h0000_0013);
    load(2, 32'h0051_0093);
    do_reset(1);
    repeat (20) @(posedge clk);
    #1;
    check("t5_req_count", req_addr_log.size(), 32'd2);
    check("t5_valid_held", {31'b0, instr_valid}, 32'h1);
    push_exp(32'h9300_5100, 32'h0, 1'b0, -1);
    push_exp(32'h1300_0000, 32'h4, 1'b0, -1);
    push_exp(32'h9300_5100, 32'h8, 1'b0, -1);
    instr_ready = 1'b1;
    wait_drain("t5_drain");

    // Redirect with a full queue: output hidden at once, queue flushed, fetch restarts at 0x8.
    load(0, 32'h0051_0093);
    load(1, 32'h0000_0013);
    load(2, 32'h0000_0013);
    do_reset(1);
    repeat (6) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    #1;
    check("t7_valid_in_redirect", {31'b0, instr_valid}, 32'h0);
    check("t7_req_in_redirect", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("t7_pc_after_redirect", instr_pc, 32'h8);
    check("t7_addr_after_redirect", imem_addr, 32'h8);
    check("t7_valid_after_flush", {31'b0, instr_valid}, 32'h0);
    push_exp(32'h1300_0000, 32'h8, 1'b0, -1);
    instr_ready = 1'b1;
    wait_drain("t7_drain");

    // Final reset applied with fetch activity in progress.
    load(0, 32'h0051_0093);
    repeat (3) @(posedge clk);
    #1;
    do_reset(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
